// File: rtl/trdb_trace_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trdb_trace_ctrl
// Purpose  : Run-control sequencer for the trace filter. Holds the
//            software-visible filter configuration (CTRL, LOWER, HIGHER,
//            START, STOP, LIMIT), drives the filter control inputs, and
//            decides when tracing is live with an arm/start/stop FSM that
//            watches the retired-instruction stream.
// Ports    : clk_i, rst_i            clock, synchronous active-high reset
//            cfg_we_i/addr/wdata     register write port (one write/cycle)
//            cfg_err_o               one-cycle pulse when a write is dropped
//            ivalid_i, iaddr_i       retired-instruction stream
//            trace_activated_o       combinational "trace this instruction"
//            apply_filters_o         CTRL[1]
//            trace_range_o           CTRL[2]
//            trace_lower_addr_o      LOWER register
//            trace_higher_addr_o     HIGHER register
//            state_o                 0 IDLE, 1 ARMED, 2 TRACING, 3 DONE
//            traced_cnt_o            instructions traced since last arm
// Revision : 1.0 - initial release
// ============================================================================
module trdb_trace_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cfg_we_i,
    input  logic [2:0]       cfg_addr_i,
    input  logic [XLEN-1:0]  cfg_wdata_i,
    output logic             cfg_err_o,
    input  logic             ivalid_i,
    input  logic [XLEN-1:0]  iaddr_i,
    output logic             trace_activated_o,
    output logic             apply_filters_o,
    output logic             trace_range_o,
    output logic [XLEN-1:0]  trace_lower_addr_o,
    output logic [XLEN-1:0]  trace_higher_addr_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] traced_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_TRACING = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [2:0] C_ADDR_CTRL   = 3'd0;
    localparam logic [2:0] C_ADDR_LOWER  = 3'd1;
    localparam logic [2:0] C_ADDR_HIGHER = 3'd2;
    localparam logic [2:0] C_ADDR_START  = 3'd3;
    localparam logic [2:0] C_ADDR_STOP   = 3'd4;
    localparam logic [2:0] C_ADDR_LIMIT  = 3'd5;

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // CTRL bit positions
    localparam int C_BIT_ARM        = 0;
    localparam int C_BIT_APPLY      = 1;
    localparam int C_BIT_RANGE      = 2;
    localparam int C_BIT_START_ADDR = 3;
    localparam int C_BIT_STOP_ADDR  = 4;
    localparam int C_BIT_STOP_CNT   = 5;
    localparam int C_BIT_ABORT      = 6;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             r_apply;
    logic             r_range;
    logic             r_stop_on_addr;
    logic             r_stop_on_count;
    logic [XLEN-1:0]  r_lower;
    logic [XLEN-1:0]  r_higher;
    logic [XLEN-1:0]  r_start;
    logic [XLEN-1:0]  r_stop;
    logic [CNT_W-1:0] r_limit;

    // start_on_addr only matters at the moment of arming, and arming always
    // comes from the same CTRL write that carries the bit, so the decision
    // is taken straight from the write data and no copy is kept.

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    logic w_cfg_open;
    logic w_ctrl_wr;
    logic w_reg_addr;
    logic w_reg_wr;
    logic w_err_next;
    logic w_abort;
    logic w_arm;

    always_comb begin
        // Data registers may only change while no trace run is in flight.
        w_cfg_open = (r_state == S_IDLE) || (r_state == S_DONE);
        w_ctrl_wr  = cfg_we_i && (cfg_addr_i == C_ADDR_CTRL);
        w_reg_addr = (cfg_addr_i >= C_ADDR_LOWER) && (cfg_addr_i <= C_ADDR_LIMIT);
        w_reg_wr   = cfg_we_i && w_reg_addr && w_cfg_open;
        // Unmapped addresses always error; mapped data registers error
        // only when locked. CTRL writes never error.
        w_err_next = cfg_we_i && (cfg_addr_i != C_ADDR_CTRL)
                     && (!w_reg_addr || !w_cfg_open);
        // Abort beats arm when both are set in one write.
        w_abort    = w_ctrl_wr && cfg_wdata_i[C_BIT_ABORT];
        // Arm outside IDLE/DONE is silently ignored.
        w_arm      = w_ctrl_wr && cfg_wdata_i[C_BIT_ARM]
                     && !cfg_wdata_i[C_BIT_ABORT] && w_cfg_open;
    end

    // ------------------------------------------------------------------
    // Trigger detection
    // ------------------------------------------------------------------
    logic             w_start_hit;
    logic             w_stop_hit;
    logic             w_cnt_hit;
    logic             w_end_hit;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_cnt_sat;

    always_comb begin
        w_cnt_inc   = r_cnt + C_CNT_ONE;
        // Saturating increment: counter sticks at all-ones.
        w_cnt_sat   = (r_cnt == C_CNT_MAX) ? r_cnt : w_cnt_inc;
        w_start_hit = ivalid_i && (iaddr_i == r_start);
        w_stop_hit  = r_stop_on_addr && ivalid_i && (iaddr_i == r_stop);
        // LIMIT of zero disables the count stop. Once saturated the
        // wrapped increment is zero and can never match a non-zero limit.
        w_cnt_hit   = r_stop_on_count && (r_limit != '0) && ivalid_i
                      && (w_cnt_inc == r_limit);
        w_end_hit   = w_stop_hit || w_cnt_hit;
    end

    // ------------------------------------------------------------------
    // FSM next-state / outputs
    // ------------------------------------------------------------------
    state_t           w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_active;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_active     = 1'b0;

        unique case (r_state)
            S_IDLE: begin
            end
            S_ARMED: begin
                // The start instruction itself is traced; if it is also a
                // stop trigger the run is exactly one instruction long.
                w_active = w_start_hit;
                if (w_start_hit) begin
                    w_cnt_next   = w_cnt_sat;
                    w_state_next = w_end_hit ? S_DONE : S_TRACING;
                end
            end
            S_TRACING: begin
                w_active = 1'b1;
                if (ivalid_i) begin
                    w_cnt_next = w_cnt_sat;
                end
                if (w_end_hit) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
            end
            default: begin
            end
        endcase

        // Commands override triggers. trace_activated_o deliberately keeps
        // its pre-command value for this cycle.
        if (w_abort) begin
            w_state_next = S_IDLE;
            w_cnt_next   = r_cnt;
        end else if (w_arm) begin
            w_state_next = cfg_wdata_i[C_BIT_START_ADDR] ? S_ARMED : S_TRACING;
            w_cnt_next   = '0;
        end
    end

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_err           <= 1'b0;
            r_apply         <= 1'b0;
            r_range         <= 1'b0;
            r_stop_on_addr  <= 1'b0;
            r_stop_on_count <= 1'b0;
            r_lower         <= '0;
            r_higher        <= '0;
            r_start         <= '0;
            r_stop          <= '0;
            r_limit         <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_err   <= w_err_next;

            // Mode bits follow every CTRL write regardless of state.
            if (w_ctrl_wr) begin
                r_apply         <= cfg_wdata_i[C_BIT_APPLY];
                r_range         <= cfg_wdata_i[C_BIT_RANGE];
                r_stop_on_addr  <= cfg_wdata_i[C_BIT_STOP_ADDR];
                r_stop_on_count <= cfg_wdata_i[C_BIT_STOP_CNT];
            end

            if (w_reg_wr) begin
                unique case (cfg_addr_i)
                    C_ADDR_LOWER:  r_lower  <= cfg_wdata_i;
                    C_ADDR_HIGHER: r_higher <= cfg_wdata_i;
                    C_ADDR_START:  r_start  <= cfg_wdata_i;
                    C_ADDR_STOP:   r_stop   <= cfg_wdata_i;
                    C_ADDR_LIMIT:  r_limit  <= cfg_wdata_i[CNT_W-1:0];
                    default: begin
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cfg_err_o           = r_err;
    assign trace_activated_o   = w_active;
    assign apply_filters_o     = r_apply;
    assign trace_range_o       = r_range;
    assign trace_lower_addr_o  = r_lower;
    assign trace_higher_addr_o = r_higher;
    assign state_o             = r_state;
    assign traced_cnt_o        = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_trdb_trace_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_trdb_trace_ctrl
// Purpose  : Self-checking bench for trdb_trace_ctrl. A table of directed
//            vectors gives per-cycle inputs, the expected combinational
//            trace_activated_o before the edge, and the expected registered
//            outputs after the edge. A few hand sequences cover reset and
//            the mode/bound outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trdb_trace_ctrl;

    localparam int XLEN  = 32;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             cfg_we;
    logic [2:0]       cfg_addr;
    logic [XLEN-1:0]  cfg_wdata;
    logic             cfg_err;
    logic             ivalid;
    logic [XLEN-1:0]  iaddr;
    logic             trace_activated;
    logic             apply_filters;
    logic             trace_range;
    logic [XLEN-1:0]  lower_addr;
    logic [XLEN-1:0]  higher_addr;
    logic [1:0]       state;
    logic [CNT_W-1:0] traced_cnt;

    trdb_trace_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) u_dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .cfg_we_i            (cfg_we),
        .cfg_addr_i          (cfg_addr),
        .cfg_wdata_i         (cfg_wdata),
        .cfg_err_o           (cfg_err),
        .ivalid_i            (ivalid),
        .iaddr_i             (iaddr),
        .trace_activated_o   (trace_activated),
        .apply_filters_o     (apply_filters),
        .trace_range_o       (trace_range),
        .trace_lower_addr_o  (lower_addr),
        .trace_higher_addr_o (higher_addr),
        .state_o             (state),
        .traced_cnt_o        (traced_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic        iv;
        logic [31:0] ia;
        logic        act;    // expected trace_activated_o before the edge
        logic [1:0]  st;     // expected state_o after the edge
        logic [15:0] cnt;    // expected traced_cnt_o after the edge
        logic        err;    // expected cfg_err_o after the edge
        logic [31:0] lower;  // expected trace_lower_addr_o after the edge
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   failures;

    localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, TRACING = 2'd2, DONE = 2'd3;

    task automatic add(input logic we, input logic [2:0] addr, input logic [31:0] wdata,
                       input logic iv, input logic [31:0] ia, input logic act,
                       input logic [1:0] st, input logic [15:0] cnt, input logic err,
                       input logic [31:0] lower);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.iv = iv; v.ia = ia;
        v.act = act; v.st = st; v.cnt = cnt; v.err = err; v.lower = lower;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] addr, input logic [31:0] wdata,
                         input logic iv, input logic [31:0] ia);
        cfg_we = we; cfg_addr = addr; cfg_wdata = wdata; ivalid = iv; iaddr = ia;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        drive(1'b0, 3'd0, 32'h0, 1'b0, 32'h0);
        repeat (3) tick();
        rst = 1'b0;

        // ---- reset / idle ------------------------------------------------
        for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 0, IDLE, 0, 0, 0);
        // ---- count stop: LIMIT=3, arm + stop_on_count ----------------------
        add(1, 5, 32'h3,   0, 0,       0, IDLE,    0, 0, 0);
        add(1, 0, 32'h21,  0, 0,       0, TRACING, 0, 0, 0);
        add(0, 0, 0,       1, 32'h10,  1, TRACING, 1, 0, 0);
        add(0, 0, 0,       1, 32'h14,  1, TRACING, 2, 0, 0);
        add(0, 0, 0,       1, 32'h18,  1, DONE,    3, 0, 0);
        add(0, 0, 0,       1, 32'h1C,  0, DONE,    3, 0, 0);
        add(0, 0, 0,       1, 32'h20,  0, DONE,    3, 0, 0);
        add(0, 0, 0,       1, 32'h24,  0, DONE,    3, 0, 0);
        // ---- start/stop address window -----------------------------------
        add(1, 3, 32'h100, 0, 0,       0, DONE,    3, 0, 0);
        add(1, 4, 32'h180, 0, 0,       0, DONE,    3, 0, 0);
        add(1, 0, 32'h19,  0, 0,       0, ARMED,   0, 0, 0);
        add(0, 0, 0,       1, 32'h0F8, 0, ARMED,   0, 0, 0);
        add(0, 0, 0,       1, 32'h0FC, 0, ARMED,   0, 0, 0);
        add(0, 0, 0,       1, 32'h100, 1, TRACING, 1, 0, 0);
        add(0, 0, 0,       1, 32'h104, 1, TRACING, 2, 0, 0);
        add(0, 0, 0,       1, 32'h180, 1, DONE,    3, 0, 0);
        add(0, 0, 0,       1, 32'h184, 0, DONE,    3, 0, 0);
        // ---- START == STOP: ARMED -> DONE in one instruction ---------------
        add(1, 3, 32'h200, 0, 0,       0, DONE,    3, 0, 0);
        add(1, 4, 32'h200, 0, 0,       0, DONE,    3, 0, 0);
        add(1, 0, 32'h19,  0, 0,       0, ARMED,   0, 0, 0);
        add(0, 0, 0,       1, 32'h200, 1, DONE,    1, 0, 0);
        add(0, 0, 0,       1, 32'h204, 0, DONE,    1, 0, 0);
        // ---- locked LOWER write, ignored re-arm, abort ---------------------
        add(1, 0, 32'h01,  0, 0,       0, TRACING, 0, 0, 0);
        add(1, 1, 32'h40,  0, 0,       1, TRACING, 0, 1, 0);
        add(0, 0, 0,       0, 0,       1, TRACING, 0, 0, 0);
        add(1, 0, 32'h01,  0, 0,       1, TRACING, 0, 0, 0);
        add(1, 0, 32'h41,  0, 0,       1, IDLE,    0, 0, 0);
        // ---- reach DONE, then LOWER write is accepted ----------------------
        add(1, 0, 32'h21,  0, 0,       0, TRACING, 0, 0, 0);
        add(0, 0, 0,       1, 32'h30,  1, TRACING, 1, 0, 0);
        add(0, 0, 0,       1, 32'h34,  1, TRACING, 2, 0, 0);
        add(0, 0, 0,       1, 32'h38,  1, DONE,    3, 0, 0);
        add(1, 1, 32'h40,  0, 0,       0, DONE,    3, 0, 32'h40);
        add(0, 0, 0,       0, 0,       0, DONE,    3, 0, 32'h40);
        // abort + arm bits together from DONE: abort wins, count kept
        add(1, 0, 32'h41,  0, 0,       0, IDLE,    3, 0, 32'h40);
        // ---- abort during TRACING with ivalid: no increment ----------------
        add(1, 0, 32'h01,  0, 0,       0, TRACING, 0, 0, 32'h40);
        add(0, 0, 0,       1, 32'h50,  1, TRACING, 1, 0, 32'h40);
        add(0, 0, 0,       1, 32'h54,  1, TRACING, 2, 0, 32'h40);
        add(1, 0, 32'h41,  1, 32'h58,  1, IDLE,    2, 0, 32'h40);
        add(1, 0, 32'h01,  0, 0,       0, TRACING, 0, 0, 32'h40);
        // ---- unmapped address errors even when unlocked --------------------
        add(1, 0, 32'h40,  0, 0,       1, IDLE,    0, 0, 32'h40);
        add(1, 6, 32'hFF,  0, 0,       0, IDLE,    0, 1, 32'h40);
        add(1, 7, 32'hFF,  0, 0,       0, IDLE,    0, 1, 32'h40);
        add(0, 0, 0,       0, 0,       0, IDLE,    0, 0, 32'h40);
        // ---- LIMIT = 0 disables count stop ---------------------------------
        add(1, 5, 32'h0,   0, 0,       0, IDLE,    0, 0, 32'h40);
        add(1, 0, 32'h21,  0, 0,       0, TRACING, 0, 0, 32'h40);
        add(0, 0, 0,       1, 32'h60,  1, TRACING, 1, 0, 32'h40);
        add(0, 0, 0,       1, 32'h64,  1, TRACING, 2, 0, 32'h40);
        add(0, 0, 0,       1, 32'h68,  1, TRACING, 3, 0, 32'h40);
        add(0, 0, 0,       0, 0,       1, TRACING, 3, 0, 32'h40);

        // ---- reset-state outputs not covered by the table ------------------
        chk("rst_apply",  -1, {31'b0, apply_filters}, 32'h0);
        chk("rst_range",  -1, {31'b0, trace_range},   32'h0);
        chk("rst_higher", -1, higher_addr,            32'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].iv, vecs[i].ia);
            #2;
            chk("activated", i, {31'b0, trace_activated}, {31'b0, vecs[i].act});
            tick();
            chk("state",  i, {30'b0, state},      {30'b0, vecs[i].st});
            chk("count",  i, {16'b0, traced_cnt}, {16'b0, vecs[i].cnt});
            chk("err",    i, {31'b0, cfg_err},    {31'b0, vecs[i].err});
            chk("lower",  i, lower_addr,          vecs[i].lower);
        end

        // ---- hand sequence: mode bits and HIGHER bound ---------------------
        drive(1, 0, 32'h40, 0, 0); tick();              // abort -> IDLE
        chk("abort_idle", 100, {30'b0, state}, {30'b0, IDLE});
        drive(1, 2, 32'h80, 0, 0); tick();
        drive(1, 0, 32'h06, 0, 0); tick();              // apply + range, no arm
        drive(0, 0, 0, 0, 0);
        chk("apply",      101, {31'b0, apply_filters}, 32'h1);
        chk("range",      102, {31'b0, trace_range},   32'h1);
        chk("higher",     103, higher_addr,            32'h80);
        chk("mode_idle",  104, {30'b0, state},         {30'b0, IDLE});
        drive(1, 0, 32'h02, 0, 0); tick();              // range bit cleared
        drive(0, 0, 0, 0, 0);
        chk("range_clr",  105, {31'b0, trace_range},   32'h0);
        chk("apply_keep", 106, {31'b0, apply_filters}, 32'h1);

        // ---- hand sequence: reset while TRACING ----------------------------
        drive(1, 0, 32'h01, 0, 0); tick();
        drive(0, 0, 0, 1, 32'h70); tick();
        chk("pre_rst_st", 107, {30'b0, state}, {30'b0, TRACING});
        rst = 1'b1;
        drive(0, 0, 0, 0, 0); tick();
        rst = 1'b0;
        chk("rst_st",     108, {30'b0, state},         {30'b0, IDLE});
        chk("rst_cnt",    109, {16'b0, traced_cnt},    32'h0);
        chk("rst_lower",  110, lower_addr,             32'h0);
        chk("rst_higher2",111, higher_addr,            32'h0);
        chk("rst_apply2", 112, {31'b0, apply_filters}, 32'h0);
        chk("rst_act",    113, {31'b0, trace_activated}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/trdb_trace_ctrl.md
Name: trdb_trace_ctrl

Overview:
- Run-control sequencer for the trace filter: holds the software-visible filter configuration and drives the filter's control inputs.
- Control inputs driven: trace activation, filter enable, range enable, lower/upper range bounds.
- Decides when tracing is live using an arm/start/stop FSM: optional start-address trigger, stop-address trigger and instruction-count limit.
- Sits between the debug register interface and the filter, and observes the same retired-instruction stream.

Parameters:
- XLEN, 32, instruction address / config data width.
- CNT_W, 16, width of the traced-instruction counter and count limit.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- cfg_we_i  in  1  config write strobe, one write per cycle, always accepted.
- cfg_addr_i  in  3  register select: 0 CTRL, 1 LOWER, 2 HIGHER, 3 START, 4 STOP, 5 LIMIT.
- cfg_wdata_i  in  XLEN  write data.
- cfg_err_o  out  1  one-cycle pulse: write dropped (see Behaviour).
- ivalid_i  in  1  instruction retired this cycle.
- iaddr_i  in  XLEN  address of retired instruction.
- trace_activated_o  out  1  to filter trace_activated input.
- apply_filters_o  out  1  CTRL[1], registered.
- trace_range_o  out  1  CTRL[2], registered.
- trace_lower_addr_o  out  XLEN  LOWER register.
- trace_higher_addr_o  out  XLEN  HIGHER register.
- state_o  out  2  0 IDLE, 1 ARMED, 2 TRACING, 3 DONE.
- traced_cnt_o  out  CNT_W  instructions traced since last arm.

Behaviour:
- Reset: state IDLE; all registers, traced_cnt_o, cfg_err_o and all outputs 0.
- CTRL register bits:
  - [1] apply_filters, [2] trace_range: stored on every CTRL write.
  - [3] start_on_addr, [4] stop_on_addr, [5] stop_on_count: stored on every CTRL write.
  - [0] arm, [6] abort: self-clearing commands.
- Register write rules:
  - Writes to addr 1-5 update one cycle after the strobe, only in IDLE or DONE.
  - In ARMED or TRACING those writes are dropped and cfg_err_o pulses the next cycle.
  - Addr 6-7: dropped, cfg_err_o pulses.
- Commands:
  - Abort in any state -> IDLE next cycle. Abort wins over arm in the same write.
  - Arm is honoured in IDLE or DONE only: traced_cnt cleared, next state ARMED if start_on_addr else TRACING.
  - Arm in ARMED/TRACING is ignored and does not raise cfg_err_o.
- start_hit = ivalid_i && iaddr_i == START.
- stop_hit = stop_on_addr && ivalid_i && iaddr_i == STOP.
- cnt_hit = stop_on_count && LIMIT != 0 && ivalid_i && traced_cnt+1 == LIMIT.
- trace_activated_o is combinational, so trigger instructions are traced in the same cycle:
  - 1 in TRACING.
  - 1 in ARMED when start_hit.
  - 0 otherwise.
- ARMED:
  - start_hit -> TRACING; traced_cnt increments for that instruction.
  - If stop_hit or cnt_hit in the same cycle (START == STOP, or LIMIT == 1) -> DONE directly, with exactly one instruction traced.
- TRACING:
  - Each ivalid_i increments traced_cnt, saturating at all-ones.
  - stop_hit or cnt_hit -> DONE next cycle; that instruction is traced. Both at once count as a single transition.
- DONE: trace_activated_o = 0; holds until arm or abort.
- LIMIT == 0 disables count stop even if stop_on_count = 1.
- Command vs. config in one cycle: a CTRL write takes priority over triggers; abort in TRACING suppresses that cycle's increment.
  - Exception: trace_activated_o for the current cycle still reflects the pre-write state.
- Bounds: no check on LOWER < HIGHER; equal bounds mean an empty range, handled by the filter.
- Reset mid-TRACING: IDLE next edge, config lost.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, state_o=0, no cfg_err_o.
- LIMIT=3, CTRL=0x21 (arm + stop_on_count), 6 back-to-back ivalid -> trace_activated_o high for exactly instructions 1-3; state_o=3 after 3rd; traced_cnt_o=3.
- START=0x100, STOP=0x180, CTRL=0x19; retire 0x0F8, 0x0FC, 0x100, 0x104, 0x180, 0x184 -> traced only 0x100, 0x104, 0x180; traced_cnt_o=3; state DONE.
- START=STOP=0x200, CTRL=0x19; retire 0x200 -> one traced cycle, ARMED->DONE directly, traced_cnt_o=1.
- Write LOWER=0x40 during TRACING -> cfg_err_o pulses one cycle, trace_lower_addr_o unchanged; same write in DONE -> output 0x40, no error.
- Abort (CTRL=0x41) while TRACING with ivalid_i high -> IDLE next cycle, count not incremented; re-arm with CTRL=0x01 -> TRACING, traced_cnt_o=0.
